// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   On-chip checker that watches the r/y/g lamp outputs of the traffic light
//   controller and decodes them back into a phase. It checks the lamp
//   pattern (exactly one lamp lit), the phase order GREEN->YELLOW->RED->GREEN
//   and the dwell time of each phase against PHASE_CYCLES +/- TOL.
//   Two-stage pipeline: lamps are registered into s_q, then the tracking FSM
//   and all outputs are registered from the decode of s_q.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   r, y, g      in   red / yellow / green lamps from the controller
//   light        out  decoded phase: 0=RED 1=YELLOW 2=GREEN 3=none/illegal
//   light_valid  out  1 while the FSM is tracking a phase
//   phase_done   out  1-clk pulse on each legal lamp change
//   phase_count  out  number of phase_done pulses, wraps to 0
//   err_pattern  out  1-clk pulse for each sample without exactly one lamp lit
//   err_seq      out  1-clk pulse on an out-of-order lamp change
//   err_time     out  1-clk pulse when a dwell falls outside the window
//   err_flags    out  sticky {time,seq,pattern}      (TLM_STICKY_EN only)
//   clr_err      in   clears err_flags on next clock (TLM_STICKY_EN only)
//
// Build option: define TLM_STICKY_EN to add the sticky error flags.

module traffic_light_monitor #(
  parameter int unsigned PHASE_CYCLES = 27000002,
  parameter int unsigned TOL          = 2,
  parameter int unsigned CW           = 32,
  parameter int unsigned PCW          = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r,
  input  logic           y,
  input  logic           g,
  output logic [1:0]     light,
  output logic           light_valid,
  output logic           phase_done,
  output logic [PCW-1:0] phase_count,
  output logic           err_pattern,
  output logic           err_seq,
  output logic           err_time
`ifdef TLM_STICKY_EN
  ,
  output logic [2:0]     err_flags,
  input  logic           clr_err
`endif
);

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_YELLOW = 2'd1,
    PH_GREEN  = 2'd2,
    PH_NONE   = 2'd3
  } phase_e;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  localparam logic [CW-1:0] DW_LIMIT = CW'(PHASE_CYCLES + TOL + 1);
  localparam logic [CW-1:0] DW_MIN   = CW'(PHASE_CYCLES - TOL);

  logic [2:0]     s_q;
  state_e         state_q, state_d;
  phase_e         cur_q, cur_d;
  phase_e         code;
  logic [CW-1:0]  dwell_q, dwell_d;
  logic           first_q, first_d;
  logic           ovr_q, ovr_d;
  logic [1:0]     light_q, light_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic [PCW-1:0] count_q, count_d;
  logic           epat_q, epat_d;
  logic           eseq_q, eseq_d;
  logic           etime_q, etime_d;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_GREEN:  next_phase = PH_YELLOW;
      PH_YELLOW: next_phase = PH_RED;
      PH_RED:    next_phase = PH_GREEN;
      default:   next_phase = PH_NONE;
    endcase
  endfunction

  always_comb begin
    case (s_q)
      3'b100:  code = PH_RED;
      3'b010:  code = PH_YELLOW;
      3'b001:  code = PH_GREEN;
      default: code = PH_NONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dwell_d = dwell_q;
    first_d = first_q;
    ovr_d   = ovr_q;
    light_d = light_q;
    valid_d = valid_q;
    count_d = count_q;
    done_d  = 1'b0;
    epat_d  = 1'b0;
    eseq_d  = 1'b0;
    etime_d = 1'b0;

    if (code == PH_NONE) begin
      epat_d  = 1'b1;
      state_d = ST_SYNC;
      light_d = PH_NONE;
      valid_d = 1'b0;
      first_d = 1'b1;
      dwell_d = '0;
      ovr_d   = 1'b0;
    end else if (state_q == ST_SYNC) begin
      state_d = ST_TRACK;
      cur_d   = code;
      dwell_d = CW'(1);
      first_d = 1'b1;
      ovr_d   = 1'b0;
      light_d = code;
      valid_d = 1'b1;
    end else if (code == cur_q) begin
      if (dwell_q != '1) dwell_d = dwell_q + CW'(1);
      // ovr_q remembers the overrun so it is reported once per phase
      if (dwell_d == DW_LIMIT && !ovr_q) begin
        etime_d = 1'b1;
        ovr_d   = 1'b1;
      end
    end else begin
      done_d  = 1'b1;
      count_d = count_q + PCW'(1);
      if (code != next_phase(cur_q)) eseq_d = 1'b1;
      // a phase entered from SYNC is partial, so its length is not judged
      if (!first_q && !ovr_q && dwell_q < DW_MIN) etime_d = 1'b1;
      cur_d   = code;
      dwell_d = CW'(1);
      first_d = 1'b0;
      ovr_d   = 1'b0;
      light_d = code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q     <= '0;
      state_q <= ST_SYNC;
      cur_q   <= PH_NONE;
      dwell_q <= '0;
      first_q <= 1'b1;
      ovr_q   <= 1'b0;
      light_q <= 2'd3;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      epat_q  <= 1'b0;
      eseq_q  <= 1'b0;
      etime_q <= 1'b0;
    end else begin
      s_q     <= {r, y, g};
      state_q <= state_d;
      cur_q   <= cur_d;
      dwell_q <= dwell_d;
      first_q <= first_d;
      ovr_q   <= ovr_d;
      light_q <= light_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
      epat_q  <= epat_d;
      eseq_q  <= eseq_d;
      etime_q <= etime_d;
    end
  end

  assign light       = light_q;
  assign light_valid = valid_q;
  assign phase_done  = done_q;
  assign phase_count = count_q;
  assign err_pattern = epat_q;
  assign err_seq     = eseq_q;
  assign err_time    = etime_q;

`ifdef TLM_STICKY_EN
  logic [2:0] flags_q, flags_d;

  // a new error pulse overrides a simultaneous clear
  always_comb begin
    flags_d = (clr_err ? 3'b000 : flags_q) | {etime_d, eseq_d, epat_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flags_q <= '0;
    else      flags_q <= flags_d;
  end

  assign err_flags = flags_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam logic [2:0] L_R  = 3'b100;
  localparam logic [2:0] L_Y  = 3'b010;
  localparam logic [2:0] L_G  = 3'b001;
  localparam logic [2:0] L_RG = 3'b101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       r = 1'b0, y = 1'b0, g = 1'b0;
  logic [1:0] light;
  logic       light_valid, phase_done, err_pattern, err_seq, err_time;
  logic [3:0] phase_count;
`ifdef TLM_STICKY_EN
  logic [2:0] err_flags;
  logic       clr_err = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  traffic_light_monitor #(
    .PHASE_CYCLES(10),
    .TOL         (1),
    .CW          (32),
    .PCW         (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .r          (r),
    .y          (y),
    .g          (g),
    .light      (light),
    .light_valid(light_valid),
    .phase_done (phase_done),
    .phase_count(phase_count),
    .err_pattern(err_pattern),
    .err_seq    (err_seq),
    .err_time   (err_time)
`ifdef TLM_STICKY_EN
    ,
    .err_flags  (err_flags),
    .clr_err    (clr_err)
`endif
  );

  always #5 clk = ~clk;

  // One record per lamp segment. Pulse counts and first-pulse indices are
  // attributed to the input sample that caused them; light/valid/count are
  // the values produced by the segment's last sample.
  typedef struct {
    logic [2:0] lamps;
    int         reps;
    int         n_dn, a_dn, n_sq, a_sq, n_tm, a_tm, n_pt, a_pt;
    int         light, valid, count;
  } vec_t;

  vec_t tbl[24];

  int n_dn = 0, n_sq = 0, n_tm = 0, n_pt = 0;
  int a_dn = -1, a_sq = -1, a_tm = -1, a_pt = -1;

  function automatic vec_t mk(input logic [2:0] l, input int reps,
                              input int ndn, input int adn, input int nsq, input int asq,
                              input int ntm, input int atm, input int npt, input int apt,
                              input int lt, input int vl, input int cnt);
    vec_t v;
    v.lamps = l;  v.reps = reps;
    v.n_dn = ndn; v.a_dn = adn; v.n_sq = nsq; v.a_sq = asq;
    v.n_tm = ntm; v.a_tm = atm; v.n_pt = npt; v.a_pt = apt;
    v.light = lt; v.valid = vl; v.count = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic observe(input int seg, input int idx);
    if (seg < 0) return;
    if (phase_done)  begin n_dn++; if (a_dn < 0) a_dn = idx; end
    if (err_seq)     begin n_sq++; if (a_sq < 0) a_sq = idx; end
    if (err_time)    begin n_tm++; if (a_tm < 0) a_tm = idx; end
    if (err_pattern) begin n_pt++; if (a_pt < 0) a_pt = idx; end
    if (idx == tbl[seg].reps - 1) begin
      chk($sformatf("seg%0d done_n", seg),  n_dn, tbl[seg].n_dn);
      chk($sformatf("seg%0d done_at", seg), a_dn, tbl[seg].a_dn);
      chk($sformatf("seg%0d seq_n", seg),   n_sq, tbl[seg].n_sq);
      chk($sformatf("seg%0d seq_at", seg),  a_sq, tbl[seg].a_sq);
      chk($sformatf("seg%0d time_n", seg),  n_tm, tbl[seg].n_tm);
      chk($sformatf("seg%0d time_at", seg), a_tm, tbl[seg].a_tm);
      chk($sformatf("seg%0d pat_n", seg),   n_pt, tbl[seg].n_pt);
      chk($sformatf("seg%0d pat_at", seg),  a_pt, tbl[seg].a_pt);
      chk($sformatf("seg%0d light", seg),   int'(light),       tbl[seg].light);
      chk($sformatf("seg%0d valid", seg),   int'(light_valid), tbl[seg].valid);
      chk($sformatf("seg%0d count", seg),   int'(phase_count), tbl[seg].count);
      n_dn = 0; n_sq = 0; n_tm = 0; n_pt = 0;
      a_dn = -1; a_sq = -1; a_tm = -1; a_pt = -1;
    end
  endtask

`ifdef TLM_STICKY_EN
  task automatic sstep(input logic [2:0] l, input logic c);
    @(negedge clk);
    {r, y, g} = l;
    clr_err   = c;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    int pseg;
    int pidx;

    //            lamps reps dn  at  sq  at  tm  at  pt  at  lt vl cnt
    tbl[0]  = mk(L_G,   5,  0, -1, 0, -1, 0, -1, 0, -1, 2, 1, 0);
    tbl[1]  = mk(L_Y,  10,  1,  0, 0, -1, 0, -1, 0, -1, 1, 1, 1);
    tbl[2]  = mk(L_R,  10,  1,  0, 0, -1, 0, -1, 0, -1, 0, 1, 2);
    tbl[3]  = mk(L_G,  10,  1,  0, 0, -1, 0, -1, 0, -1, 2, 1, 3);
    tbl[4]  = mk(L_Y,  10,  1,  0, 0, -1, 0, -1, 0, -1, 1, 1, 4);
    tbl[5]  = mk(L_R,  10,  1,  0, 0, -1, 0, -1, 0, -1, 0, 1, 5);
    tbl[6]  = mk(L_G,  10,  1,  0, 0, -1, 0, -1, 0, -1, 2, 1, 6);
    tbl[7]  = mk(L_R,  10,  1,  0, 1,  0, 0, -1, 0, -1, 0, 1, 7);
    tbl[8]  = mk(L_G,  10,  1,  0, 0, -1, 0, -1, 0, -1, 2, 1, 8);
    tbl[9]  = mk(L_Y,  13,  1,  0, 0, -1, 1, 11, 0, -1, 1, 1, 9);
    tbl[10] = mk(L_R,  10,  1,  0, 0, -1, 0, -1, 0, -1, 0, 1, 10);
    tbl[11] = mk(L_G,  10,  1,  0, 0, -1, 0, -1, 0, -1, 2, 1, 11);
    tbl[12] = mk(L_Y,   8,  1,  0, 0, -1, 0, -1, 0, -1, 1, 1, 12);
    tbl[13] = mk(L_R,  10,  1,  0, 0, -1, 1,  0, 0, -1, 0, 1, 13);
    tbl[14] = mk(L_G,  10,  1,  0, 0, -1, 0, -1, 0, -1, 2, 1, 14);
    tbl[15] = mk(L_Y,   9,  1,  0, 0, -1, 0, -1, 0, -1, 1, 1, 15);
    tbl[16] = mk(L_R,  10,  1,  0, 0, -1, 0, -1, 0, -1, 0, 1, 0);
    tbl[17] = mk(L_G,  10,  1,  0, 0, -1, 0, -1, 0, -1, 2, 1, 1);
    tbl[18] = mk(L_Y,  11,  1,  0, 0, -1, 0, -1, 0, -1, 1, 1, 2);
    tbl[19] = mk(L_R,   5,  1,  0, 0, -1, 0, -1, 0, -1, 0, 1, 3);
    tbl[20] = mk(L_RG,  2,  0, -1, 0, -1, 0, -1, 2,  0, 3, 0, 3);
    tbl[21] = mk(L_G,   4,  0, -1, 0, -1, 0, -1, 0, -1, 2, 1, 3);
    tbl[22] = mk(L_Y,  10,  1,  0, 0, -1, 0, -1, 0, -1, 1, 1, 4);
    tbl[23] = mk(L_R,  10,  1,  0, 0, -1, 0, -1, 0, -1, 0, 1, 5);

    // Reset held with green lit
    rst = 1'b0;
    {r, y, g} = L_G;
    repeat (3) @(posedge clk);
    #1;
    chk("rst light", int'(light), 3);
    chk("rst valid", int'(light_valid), 0);
    chk("rst done",  int'(phase_done), 0);
    chk("rst count", int'(phase_count), 0);
    chk("rst errs",  int'({err_pattern, err_seq, err_time}), 0);

    // Release: green appears two edges later
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel+1 light", int'(light), 3);
    chk("rel+1 valid", int'(light_valid), 0);
    @(posedge clk);
    #1;
    chk("rel+2 light", int'(light), 2);
    chk("rel+2 valid", int'(light_valid), 1);
    @(posedge clk);

    // Asynchronous reset mid-phase, checked before any clock edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async light", int'(light), 3);
    chk("async valid", int'(light_valid), 0);
    chk("async count", int'(phase_count), 0);

    // Table run; outputs seen after an edge belong to the previous sample
    pseg = -1;
    pidx = 0;
    for (int s = 0; s < 24; s++) begin
      for (int k = 0; k < tbl[s].reps; k++) begin
        @(negedge clk);
        rst = 1'b1;
        {r, y, g} = tbl[s].lamps;
        @(posedge clk);
        #1;
        observe(pseg, pidx);
        pseg = s;
        pidx = k;
      end
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    observe(pseg, pidx);

`ifdef TLM_STICKY_EN
    // Red is current with dwell 11 pending; every error type was seen above.
    chk("sticky all", int'(err_flags), 7);
    sstep(L_G, 1'b1);
    chk("sticky clr", int'(err_flags), 0);
    for (int i = 1; i < 10; i++) sstep(L_G, 1'b0);
    sstep(L_R, 1'b0);
    sstep(L_R, 1'b0);
    chk("sticky seq pulse", int'(err_seq), 1);
    chk("sticky seq done",  int'(phase_done), 1);
    chk("sticky seq flags", int'(err_flags), 2);
    sstep(L_R, 1'b1);
    chk("sticky clr2", int'(err_flags), 0);
    for (int i = 3; i < 12; i++) sstep(L_R, 1'b0);
    chk("sticky pre time", int'(err_time), 0);
    sstep(L_R, 1'b1);
    chk("sticky time pulse", int'(err_time), 1);
    chk("sticky time wins",  int'(err_flags), 4);
    sstep(L_R, 1'b0);
    chk("sticky hold", int'(err_flags), 4);
    chk("sticky time once", int'(err_time), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
